// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex 8N1 UART with shared baud ticks, LED mirror and TX copy.
// Define UART_RX_SYNC_EN to pass RX through a 2-flop synchronizer before the receiver.
module uart_transceiver #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD = 115200,
  parameter int TX_DIV = CLK_FREQ / BAUD,
  parameter int RX_DIV = CLK_FREQ / (BAUD * 16)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DATA_IN,
  input  logic       WR_EN,
  output logic       TX_BUSY,
  output logic       TX,
  output logic       TX2,
  input  logic       RX,
  output logic       READY,
  input  logic       READY_CLR,
  output logic [7:0] DATA_OUT,
  output logic [7:0] LEDR,
  output logic       txen,
  output logic       rxen
);
  localparam int TW = $clog2(TX_DIV + 1);
  localparam int RW = $clog2(RX_DIV + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [TW-1:0] tx_cnt_q;
  logic [RW-1:0] rx_cnt_q;
  logic txen_q, rxen_q, tx_wrap, rx_wrap;
  assign tx_wrap = tx_cnt_q == TW'(TX_DIV - 1);
  assign rx_wrap = rx_cnt_q == RW'(RX_DIV - 1);
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      txen_q <= 1'b0;
      rxen_q <= 1'b0;
    end else begin
      tx_cnt_q <= tx_wrap ? '0 : tx_cnt_q + TW'(1);
      rx_cnt_q <= rx_wrap ? '0 : rx_cnt_q + RW'(1);
      txen_q <= tx_wrap;
      rxen_q <= rx_wrap;
    end
  state_t tx_st_q, tx_st_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [3:0] tx_bit_q, tx_bit_d;
  logic tx_q, tx_d;
  // bit index 8 in DATA emits the stop level; STOP then holds it for one full tick period
  always_comb begin
    tx_st_d = tx_st_q;
    tx_byte_d = tx_byte_q;
    tx_bit_d = tx_bit_q;
    tx_d = tx_q;
    case (tx_st_q)
      IDLE: if (WR_EN) begin
        tx_st_d = START;
        tx_byte_d = DATA_IN;
      end
      START: if (txen_q) begin
        tx_st_d = DATA;
        tx_d = 1'b0;
        tx_bit_d = 4'd0;
      end
      DATA: if (txen_q) begin
        tx_d = tx_bit_q[3] | tx_byte_q[tx_bit_q[2:0]];
        tx_bit_d = tx_bit_q + 4'd1;
        tx_st_d = tx_bit_q[3] ? STOP : DATA;
      end
      STOP: if (txen_q) tx_st_d = IDLE;
      default: tx_st_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      tx_st_q <= IDLE;
      tx_byte_q <= 8'h00;
      tx_bit_q <= 4'd0;
      tx_q <= 1'b1;
    end else begin
      tx_st_q <= tx_st_d;
      tx_byte_q <= tx_byte_d;
      tx_bit_q <= tx_bit_d;
      tx_q <= tx_d;
    end
  logic rx_in;
`ifdef UART_RX_SYNC_EN
  logic [1:0] rx_sync_q;
  always_ff @(posedge CLK or posedge RST)
    if (RST) rx_sync_q <= 2'b11;
    else rx_sync_q <= {rx_sync_q[0], RX};
  assign rx_in = rx_sync_q[1];
`else
  assign rx_in = RX;
`endif
  state_t rx_st_q, rx_st_d;
  logic [3:0] rx_smp_q, rx_smp_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d, dout_q, dout_d;
  logic ready_q, ready_d, good;
  // the 4-bit sample counter wraps 15->0 on its own, so DATA and STOP start aligned
  always_comb begin
    rx_st_d = rx_st_q;
    rx_smp_d = rx_smp_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    good = 1'b0;
    if (rxen_q)
      case (rx_st_q)
        IDLE: if (!rx_in) begin
          rx_st_d = START;
          rx_smp_d = 4'd0;
        end
        START: begin
          rx_smp_d = rx_smp_q + 4'd1;
          if (rx_smp_q == 4'd7) begin
            rx_st_d = rx_in ? IDLE : DATA;
            rx_smp_d = 4'd0;
            rx_bit_d = 3'd0;
          end
        end
        DATA: begin
          rx_smp_d = rx_smp_q + 4'd1;
          if (rx_smp_q == 4'd15) begin
            rx_sh_d = {rx_in, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 3'd1;
            rx_st_d = rx_bit_q == 3'd7 ? STOP : DATA;
          end
        end
        STOP: begin
          rx_smp_d = rx_smp_q + 4'd1;
          if (rx_smp_q == 4'd15) begin
            rx_st_d = IDLE;
            good = rx_in;
          end
        end
        default: rx_st_d = IDLE;
      endcase
    dout_d = good ? rx_sh_q : dout_q;
    ready_d = good | (ready_q & ~READY_CLR);
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      rx_st_q <= IDLE;
      rx_smp_q <= 4'd0;
      rx_bit_q <= 3'd0;
      rx_sh_q <= 8'h00;
      dout_q <= 8'h00;
      ready_q <= 1'b0;
    end else begin
      rx_st_q <= rx_st_d;
      rx_smp_q <= rx_smp_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;
      dout_q <= dout_d;
      ready_q <= ready_d;
    end
  assign TX_BUSY = tx_st_q != IDLE;
  assign TX = tx_q;
  assign TX2 = tx_q;
  assign READY = ready_q;
  assign DATA_OUT = dout_q;
  assign LEDR = dout_q;
  assign txen = txen_q;
  assign rxen = rxen_q;
endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: scoreboard bench; TX line and READY monitors check against byte queues.
module tb_uart_transceiver;
  localparam int CLK_FREQ = 1600;
  localparam int BAUD = 100;
  localparam int TX_DIV = CLK_FREQ / BAUD;
  localparam int RX_DIV = CLK_FREQ / (BAUD * 16);
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic WR_EN = 1'b0;
  logic READY_CLR = 1'b0;
  logic rx_drv = 1'b1;
  logic loop = 1'b0;
  logic [7:0] DATA_IN = 8'h00;
  logic TX_BUSY, TX, TX2, READY, txen, rxen, RX;
  logic [7:0] DATA_OUT, LEDR;
  int n_cmp = 0;
  int n_bad = 0;
  bit tx_mon_en = 1'b0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  assign RX = loop ? TX : rx_drv;

  uart_transceiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .WR_EN(WR_EN), .TX_BUSY(TX_BUSY),
    .TX(TX), .TX2(TX2), .RX(RX), .READY(READY), .READY_CLR(READY_CLR),
    .DATA_OUT(DATA_OUT), .LEDR(LEDR), .txen(txen), .rxen(rxen)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp_rx);
    int k = 0;
    while (TX_BUSY && k < 40 * TX_DIV) begin
      @(negedge CLK);
      k++;
    end
    check("send_wait_idle", TX_BUSY, 0);
    WR_EN = 1'b1;
    DATA_IN = b;
    if (tx_mon_en) txq.push_back(b);
    if (exp_rx) rxq.push_back(b);
    @(negedge CLK);
    WR_EN = 1'b0;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!READY && k < 40 * TX_DIV) begin
      @(negedge CLK);
      k++;
    end
    check("ready_timeout", READY, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (TX_BUSY && k < 40 * TX_DIV) begin
      @(negedge CLK);
      k++;
    end
    check("idle_timeout", TX_BUSY, 0);
  endtask

  task automatic clear_ready();
    READY_CLR = 1'b1;
    @(negedge CLK);
    READY_CLR = 1'b0;
    check("ready_clr", READY, 0);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f = {stop, b, 1'b0};
    if (stop) rxq.push_back(b);
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (TX_DIV) @(negedge CLK);
    end
    rx_drv = 1'b1;
    repeat (2 * TX_DIV) @(negedge CLK);
  endtask

  // decodes the serial line at mid-bit, independent of the DUT's internals
  initial begin : tx_mon
    logic [7:0] b;
    int tx2_bad;
    int k;
    forever begin
      @(negedge CLK);
      if (tx_mon_en && TX === 1'b0) begin
        tx2_bad = 0;
        repeat (TX_DIV / 2) @(negedge CLK);
        check("tx_start_bit", TX, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (TX_DIV) @(negedge CLK);
          b[i] = TX;
          if (TX2 !== TX) tx2_bad++;
        end
        repeat (TX_DIV) @(negedge CLK);
        check("tx_stop_bit", TX, 1);
        check("tx_busy_in_stop", TX_BUSY, 1);
        if (TX2 !== TX) tx2_bad++;
        check("tx2_copy", tx2_bad, 0);
        check("tx_queue_depth", txq.size(), 1);
        if (txq.size() > 0) check("tx_byte", b, txq.pop_front());
        k = 0;
        while (TX_BUSY && k < 2 * TX_DIV) begin
          @(negedge CLK);
          k++;
        end
        check("tx_busy_fall", k <= TX_DIV, 1);
      end
    end
  end

  initial begin : rx_mon
    logic prev;
    logic [7:0] e;
    prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (READY && !prev) begin
        check("rx_queue_depth", rxq.size() > 0, 1);
        if (rxq.size() > 0) begin
          e = rxq.pop_front();
          check("rx_data_out", DATA_OUT, e);
          check("rx_ledr", LEDR, e);
        end
      end
      prev = READY;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] b, b2;
    int k, n;
    repeat (3) @(negedge CLK);
    check("rst_tx", TX, 1);
    check("rst_tx2", TX2, 1);
    check("rst_busy", TX_BUSY, 0);
    check("rst_ready", READY, 0);
    check("rst_data_out", DATA_OUT, 0);
    check("rst_ledr", LEDR, 0);
    check("rst_txen", txen, 0);
    check("rst_rxen", rxen, 0);
    RST = 1'b0;
    k = 0;
    while (!txen && k < 4 * TX_DIV) begin
      @(negedge CLK);
      k++;
    end
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!txen && k < 4 * TX_DIV);
    check("txen_period", k, TX_DIV);
    k = 0;
    while (!rxen && k < 4 * TX_DIV) begin
      @(negedge CLK);
      k++;
    end
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!rxen && k < 4 * TX_DIV);
    check("rxen_period", k, RX_DIV);
    b = 8'($urandom_range(0, 127)) | 8'h80;
    send_rx(b, 1'b1);
    wait_ready();
    clear_ready();
    rx_drv = 1'b0;
    repeat (4) @(negedge CLK);
    rx_drv = 1'b1;
    repeat (3 * TX_DIV) @(negedge CLK);
    check("glitch_ready", READY, 0);
    send_rx(8'h55, 1'b0);
    check("framing_ready", READY, 0);
    check("framing_data_out", DATA_OUT, b);
    b2 = 8'($urandom_range(1, 255));
    send_rx(b2, 1'b1);
    wait_ready();
    send_byte(8'h00, 1'b0);
    repeat (3 * TX_DIV) @(negedge CLK);
    check("pre_reset_busy", TX_BUSY, 1);
    check("pre_reset_tx", TX, 0);
    #2 RST = 1'b1;
    #1;
    check("async_rst_tx", TX, 1);
    check("async_rst_tx2", TX2, 1);
    check("async_rst_busy", TX_BUSY, 0);
    check("async_rst_ready", READY, 0);
    check("async_rst_data_out", DATA_OUT, 0);
    check("async_rst_ledr", LEDR, 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    tx_mon_en = 1'b1;
    loop = 1'b1;
    send_byte(8'hA5, 1'b1);
    wait_ready();
    clear_ready();
    send_byte(8'h3C, 1'b1);
    repeat (3 * TX_DIV) @(negedge CLK);
    check("busy_mid_frame", TX_BUSY, 1);
    WR_EN = 1'b1;
    DATA_IN = 8'h99;
    @(negedge CLK);
    WR_EN = 1'b0;
    wait_ready();
    check("busy_ignore_data", DATA_OUT, 8'h3C);
    clear_ready();
    wait_idle();
    repeat (2 * TX_DIV) @(negedge CLK);
    check("busy_ignore_no_frame", TX_BUSY, 0);
    READY_CLR = 1'b1;
    send_byte(8'($urandom), 1'b1);
    n = 0;
    repeat (14 * TX_DIV) begin
      @(negedge CLK);
      if (READY) n++;
    end
    READY_CLR = 1'b0;
    check("ready_set_wins", n, 1);
    send_byte(8'($urandom), 1'b1);
    wait_ready();
    repeat (5) @(negedge CLK);
    check("ready_sticky", READY, 1);
    clear_ready();
    b = 8'($urandom_range(0, 127));
    b2 = b | 8'h80;
    send_byte(b, 1'b1);
    wait_ready();
    send_byte(b2, 1'b0);
    wait_idle();
    check("overwrite_ready", READY, 1);
    check("overwrite_data_out", DATA_OUT, b2);
    check("overwrite_ledr", LEDR, b2);
    clear_ready();
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i), 1'b1);
      wait_ready();
      clear_ready();
    end
    for (int i = 0; i < 16; i++) begin
      send_byte(8'($urandom), 1'b1);
      wait_ready();
      clear_ready();
    end
    wait_idle();
    repeat (2 * TX_DIV) @(negedge CLK);
    check("txq_drained", txq.size(), 0);
    check("rxq_drained", rxq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
